// File: rtl/avr_sram_bridge.sv
// Glue between an AVR host and an 8-bit asynchronous SRAM: serially loaded
// address register plus combinational strobe and tri-state data bridging.
module avr_sram_bridge #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 8
) (
   input  logic              avr_clk,
   input  logic              avr_reset_n,
   input  logic              avr_si,
   input  logic [2:0]        avr_ctrl,
   input  logic              avr_ce,
   input  logic              avr_oe,
   input  logic              avr_we,
   inout  wire  [DATA_W-1:0] avr_data,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam logic [2:0] CMD_SHIFT = 3'b001;
   localparam logic [2:0] CMD_INC   = 3'b010;
   localparam logic [2:0] CMD_CLEAR = 3'b011;

   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] addr_next;
   logic              read_en;
   logic              write_en;

   always_comb begin
      addr_next = addr_reg;
      case (avr_ctrl)
         CMD_SHIFT: addr_next = {addr_reg[ADDR_W-2:0], avr_si};
         CMD_INC:   addr_next = addr_reg + ADDR_W'(1);
         CMD_CLEAR: addr_next = '0;
         default:   addr_next = addr_reg;
      endcase
   end

   always_ff @(posedge avr_clk or negedge avr_reset_n) begin
      if (!avr_reset_n) begin
         addr_reg <= '0;
      end else begin
         addr_reg <= addr_next;
      end
   end

   assign sram_addr = addr_reg;

   // Reset gates everything so the SRAM is deselected and both buses float.
   assign sram_ce_n = !avr_reset_n | avr_ce;
   assign sram_we_n = !avr_reset_n | avr_we | avr_ce;
   assign sram_oe_n = !avr_reset_n | avr_oe | avr_ce | !avr_we;

   // Write wins over read, so the two directions are mutually exclusive.
   assign write_en = avr_reset_n & !avr_ce & !avr_we;
   assign read_en  = avr_reset_n & !avr_ce & !avr_oe & avr_we;

   assign avr_data  = read_en  ? sram_data : {DATA_W{1'bz}};
   assign sram_data = write_en ? avr_data  : {DATA_W{1'bz}};

endmodule

// File: tb/tb_avr_sram_bridge.sv
// Directed plus randomized bench for avr_sram_bridge against a behavioural
// model of the address register and the strobe/bus rules.
module tb_avr_sram_bridge;

   localparam int ADDR_W = 21;
   localparam int DATA_W = 8;
   localparam int unsigned ADDR_MASK = (1 << ADDR_W) - 1;

   logic              avr_clk = 1'b0;
   logic              avr_reset_n;
   logic              avr_si;
   logic [2:0]        avr_ctrl;
   logic              avr_ce;
   logic              avr_oe;
   logic              avr_we;
   wire  [DATA_W-1:0] avr_data;
   logic [ADDR_W-1:0] sram_addr;
   wire  [DATA_W-1:0] sram_data;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;

   logic              tb_avr_en;
   logic [DATA_W-1:0] tb_avr_val;
   logic              tb_sram_en;
   logic [DATA_W-1:0] tb_sram_val;

   int          checks = 0;
   int          failures = 0;
   int unsigned model_addr = 0;

   assign avr_data  = tb_avr_en  ? tb_avr_val  : {DATA_W{1'bz}};
   assign sram_data = tb_sram_en ? tb_sram_val : {DATA_W{1'bz}};

   avr_sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .avr_clk     (avr_clk),
      .avr_reset_n (avr_reset_n),
      .avr_si      (avr_si),
      .avr_ctrl    (avr_ctrl),
      .avr_ce      (avr_ce),
      .avr_oe      (avr_oe),
      .avr_we      (avr_we),
      .avr_data    (avr_data),
      .sram_addr   (sram_addr),
      .sram_data   (sram_data),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n)
   );

   always #5 avr_clk = ~avr_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge with a command; model follows the command table directly.
   task automatic clk_cmd(input logic [2:0] cmd, input logic si);
      avr_ctrl = cmd;
      avr_si   = si;
      @(posedge avr_clk);
      if (!avr_reset_n) model_addr = 0;
      else if (cmd == 3'b001) model_addr = ((model_addr << 1) | 32'(si)) & ADDR_MASK;
      else if (cmd == 3'b010) model_addr = (model_addr + 1) & ADDR_MASK;
      else if (cmd == 3'b011) model_addr = 0;
      #1;
      $display("txn cmd=%b si=%b addr=%06h model=%06h", cmd, si, sram_addr, model_addr);
      check("addr", 32'(sram_addr), model_addr);
   endtask

   // Apply strobes/bus drivers, then compare all bridge outputs to the rules.
   task automatic set_bus(input string tag, input logic ce, input logic oe, input logic we,
                          input logic aen, input logic [7:0] aval,
                          input logic sen, input logic [7:0] sval);
      logic              on;
      logic              rd;
      logic              wr;
      logic [DATA_W-1:0] avr_side;
      logic [DATA_W-1:0] sram_side;
      logic [DATA_W-1:0] exp_avr;
      logic [DATA_W-1:0] exp_sram;
      avr_ce = ce; avr_oe = oe; avr_we = we;
      tb_avr_en = aen; tb_avr_val = aval;
      tb_sram_en = sen; tb_sram_val = sval;
      #1;
      on        = avr_reset_n;
      wr        = on && !ce && !we;
      rd        = on && !ce && !oe && we;
      avr_side  = aen ? aval : 8'hzz;
      sram_side = sen ? sval : 8'hzz;
      exp_avr   = aen ? aval : (rd ? sram_side : 8'hzz);
      exp_sram  = sen ? sval : (wr ? avr_side : 8'hzz);
      $display("txn %s rst_n=%b ce=%b oe=%b we=%b avr=%h sram=%h n=%b%b%b",
               tag, on, ce, oe, we, avr_data, sram_data, sram_ce_n, sram_oe_n, sram_we_n);
      check({tag, ".ce_n"}, 32'(sram_ce_n), 32'(!(on && !ce)));
      check({tag, ".we_n"}, 32'(sram_we_n), 32'(!wr));
      check({tag, ".oe_n"}, 32'(sram_oe_n), 32'(!rd));
      check({tag, ".avr_data"}, 32'(avr_data), 32'(exp_avr));
      check({tag, ".sram_data"}, 32'(sram_data), 32'(exp_sram));
   endtask

   initial begin
      logic [ADDR_W-1:0] pattern;
      logic ce, oe, we, aen, sen;
      avr_reset_n = 1'b0;
      avr_ctrl = 3'b000; avr_si = 1'b0;
      avr_ce = 1'b1; avr_oe = 1'b1; avr_we = 1'b1;
      tb_avr_en = 1'b0; tb_avr_val = '0; tb_sram_en = 1'b0; tb_sram_val = '0;

      // Reset with a read requested: everything must stay idle.
      #2;
      set_bus("reset_read", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hAA);
      check("reset_addr", 32'(sram_addr), 32'h0);
      clk_cmd(3'b001, 1'b1);
      clk_cmd(3'b010, 1'b0);
      avr_reset_n = 1'b1;
      set_bus("idle", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      clk_cmd(3'b000, 1'b0);

      // Serial load, MSB first, then hold.
      pattern = 21'h0A5A5A;
      for (int i = ADDR_W - 1; i >= 0; i--) clk_cmd(3'b001, pattern[i]);
      check("load_0A5A5A", 32'(sram_addr), 32'h0A5A5A);
      for (int i = 0; i < 3; i++) clk_cmd(3'b000, 1'b1);
      check("hold_0A5A5A", 32'(sram_addr), 32'h0A5A5A);

      // Increment wrap and clear.
      for (int i = 0; i < ADDR_W; i++) clk_cmd(3'b001, 1'b1);
      check("load_max", 32'(sram_addr), 32'h1FFFFF);
      clk_cmd(3'b010, 1'b0);
      check("inc_wrap", 32'(sram_addr), 32'h0);
      clk_cmd(3'b010, 1'b0);
      check("inc_one", 32'(sram_addr), 32'h1);
      clk_cmd(3'b011, 1'b0);
      check("clear", 32'(sram_addr), 32'h0);

      // Directed bus cases.
      set_bus("read",      1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hAA);
      set_bus("read_end",  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hAA);
      set_bus("write",     1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
      set_bus("write_nd",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      set_bus("conflict",  1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
      set_bus("desel_rd",  1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hAA);
      set_bus("desel_wr",  1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
      set_bus("desel_all", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

      // Reset mid-shift during a read: address lost, bridge idles at once.
      for (int i = 0; i < 10; i++) clk_cmd(3'b001, 1'($urandom_range(0, 1)));
      avr_reset_n = 1'b0;
      model_addr = 0;
      set_bus("reset_mid", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A);
      check("reset_mid_addr", 32'(sram_addr), 32'h0);
      avr_reset_n = 1'b1;
      clk_cmd(3'b000, 1'b0);

      // Randomized commands and bus traffic; drivers never contend.
      for (int n = 0; n < 300; n++) begin
         clk_cmd(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         ce = 1'($urandom_range(0, 1));
         oe = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         aen = 1'($urandom_range(0, 1)) && !(!ce && !oe && we);
         sen = 1'($urandom_range(0, 1)) && !(!ce && !we);
         set_bus("rand", ce, oe, we, aen, 8'($urandom), sen, 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
